// File: rtl/quad_decoder_pkg.sv
// Shared phase-state encodings, direction constants and the transition
// classifier used by the quadrature decoder.
package quad_decoder_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic legal;
        logic up;
    } step_t;

    // Phase states are written {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic step_t classify(input logic [1:0] prev, input logic [1:0] curr);
        step_t r;
        r = '{legal: 1'b0, up: DIR_DOWN};
        case ({prev, curr})
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}:
                r = '{legal: 1'b1, up: DIR_UP};
            {PH_10, PH_00}, {PH_11, PH_10}, {PH_01, PH_11}, {PH_00, PH_01}:
                r = '{legal: 1'b1, up: DIR_DOWN};
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_decoder_filter.sv
// One encoder phase: two-flop synchroniser followed by a stability filter
// that only moves the output level after FILT_LEN consecutive differing samples.
module quad_input_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic prime,
    input  logic phase,
    output logic level
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    // While priming, the level follows the synchroniser so an idle non-zero
    // input is adopted as the starting position rather than seen as motion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= phase;
            sync2 <= sync1;
            if (prime) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILT_LEN - 1)) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B phases are compared cycle to cycle to
// produce a step pulse, direction, wrapping position count and sticky error.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    input  logic             phase_a,
    input  logic             phase_b,
    output logic             step,
    output logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam int PRIME_CYCLES = FILT_LEN + 2;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);

    logic [PW-1:0] prime_cnt;
    logic          priming;
    logic          filt_a;
    logic          filt_b;
    logic [1:0]    curr_state;
    logic [1:0]    prev_state;
    step_t         dec;
    logic          illegal;
    logic          active;
    logic          take_step;

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .prime (priming),
        .phase (phase_a),
        .level (filt_a)
    );

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .prime (priming),
        .phase (phase_b),
        .level (filt_b)
    );

    assign priming    = (prime_cnt != PW'(PRIME_CYCLES));
    assign curr_state = {filt_a, filt_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt <= '0;
        end else if (priming) begin
            prime_cnt <= prime_cnt + PW'(1);
        end
    end

    always_comb begin
        dec       = classify(prev_state, curr_state);
        illegal   = ((prev_state ^ curr_state) == 2'b11);
        active    = en && !priming;
        take_step = active && dec.legal;
    end

    // prev_state tracks the filtered phases even when disabled, so that
    // re-enabling never sees a stale position as a transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state <= PH_00;
            step       <= 1'b0;
            dir        <= DIR_UP;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            prev_state <= curr_state;
            step       <= take_step;
            if (take_step) begin
                dir <= dec.up;
            end
            if (clr) begin
                count <= '0;
            end else if (take_step) begin
                count <= dec.up ? count + CNT_W'(1) : count - CNT_W'(1);
            end
            if (active && illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed vector table, hand-written
// corner sequences, then random motion checked against a position model.
`timescale 1ns/1ps
module tb_quad_decoder;

    localparam int CNT_W    = 16;
    localparam int FILT_LEN = 3;
    // Edge index (1 = capturing edge) on which the step is registered.
    localparam int LAT      = FILT_LEN + 3;

    logic             clk;
    logic             reset;
    logic             en;
    logic             clr;
    logic             err_clr;
    logic             phase_a;
    logic             phase_b;
    logic             step;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic             err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic             a;
        logic             b;
        logic             clr_first;
        logic             exp_dir;
        logic [CNT_W-1:0] exp_count;
    } vec_t;

    vec_t       vecs [8];
    logic [1:0] gray [4];

    quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (clr),
        .err_clr (err_clr),
        .phase_a (phase_a),
        .phase_b (phase_b),
        .step    (step),
        .dir     (dir),
        .count   (count),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives the phases, then runs hold cycles sampling step #1 after each edge.
    task automatic apply_stimulus(input logic a, input logic b, input int hold,
                                  output int pulses, output int first_k);
        phase_a = a;
        phase_b = b;
        pulses  = 0;
        first_k = 0;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (k == 1) begin
                clr     = 1'b0;
                err_clr = 1'b0;
            end
        end
    endtask

    int               pulses;
    int               fk;
    int               p2;
    int               pos;
    int               act;
    int               hold;
    int               gl;
    logic             en_r;
    logic             do_clr;
    logic             do_eclr;
    logic             ga;
    logic             gb;
    int               m_pos;
    logic [CNT_W-1:0] m_count;
    logic             m_dir;
    logic             m_err;
    int               m_pulses;

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0002};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0003};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0004};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};

        reset = 1'b1; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
        phase_a = 1'b0; phase_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_step", {31'd0, step}, 32'd0);
        check_output("reset_dir", {31'd0, dir}, 32'd1);
        check_output("reset_count", {16'd0, count}, 32'd0);
        check_output("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 10, pulses, fk);
        check_output("prime_no_step", pulses, 0);

        // Rotation table: forward, clear, reverse wrap, forward wrap.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr_first) begin
                clr = 1'b1;
                @(posedge clk);
                #1;
                clr = 1'b0;
                check_output($sformatf("vec%0d_clr", i), {16'd0, count}, 32'd0);
            end
            apply_stimulus(vecs[i].a, vecs[i].b, 10, pulses, fk);
            check_output($sformatf("vec%0d_pulses", i), pulses, 1);
            check_output($sformatf("vec%0d_latency", i), fk, LAT);
            check_output($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, vecs[i].exp_dir});
            check_output($sformatf("vec%0d_count", i), {16'd0, count}, {16'd0, vecs[i].exp_count});
            check_output($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
        end

        // Glitch rejection at the FILT_LEN boundary.
        apply_stimulus(1'b1, 1'b0, FILT_LEN - 1, pulses, fk);
        apply_stimulus(1'b0, 1'b0, 12, p2, fk);
        check_output("glitch_pulses", pulses + p2, 0);
        check_output("glitch_count", {16'd0, count}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 10, pulses, fk);
        check_output("held_pulses", pulses, 1);
        check_output("held_count", {16'd0, count}, 32'd1);
        apply_stimulus(1'b0, 1'b0, 10, pulses, fk);
        check_output("back_count", {16'd0, count}, 32'd0);
        check_output("back_dir", {31'd0, dir}, 32'd0);

        // Illegal jump, clear, then clear coinciding with a new illegal jump.
        apply_stimulus(1'b1, 1'b1, 10, pulses, fk);
        check_output("illegal_pulses", pulses, 0);
        check_output("illegal_err", {31'd0, err}, 32'd1);
        check_output("illegal_count", {16'd0, count}, 32'd0);
        check_output("illegal_dir", {31'd0, dir}, 32'd0);
        err_clr = 1'b1;
        apply_stimulus(1'b1, 1'b1, 3, pulses, fk);
        check_output("errclr_err", {31'd0, err}, 32'd0);
        phase_a = 1'b0;
        phase_b = 1'b0;
        pulses  = 0;
        for (int k = 1; k <= 10; k++) begin
            err_clr = (k <= LAT);
            @(posedge clk);
            #1;
            if (step === 1'b1) pulses++;
        end
        err_clr = 1'b0;
        check_output("setwins_err", {31'd0, err}, 32'd1);
        check_output("setwins_pulses", pulses, 0);
        err_clr = 1'b1;
        apply_stimulus(1'b0, 1'b0, 3, pulses, fk);
        check_output("errclr2_err", {31'd0, err}, 32'd0);

        // Count to 41, then clear on the edge of the 42nd step.
        pos = 0;
        for (int i = 0; i < 41; i++) begin
            pos = (pos + 1) % 4;
            apply_stimulus(gray[pos][1], gray[pos][0], 8, pulses, fk);
        end
        check_output("count41", {16'd0, count}, 32'd41);
        pos = 2;
        phase_a = gray[pos][1];
        phase_b = gray[pos][0];
        pulses  = 0;
        for (int k = 1; k <= 10; k++) begin
            clr = (k == LAT);
            @(posedge clk);
            #1;
            if (step === 1'b1) pulses++;
        end
        clr = 1'b0;
        check_output("clrstep_pulses", pulses, 1);
        check_output("clrstep_count", {16'd0, count}, 32'd0);
        check_output("clrstep_dir", {31'd0, dir}, 32'd1);

        // Disabled: three down moves leave count and dir untouched.
        en = 1'b0;
        p2 = 0;
        for (int i = 0; i < 3; i++) begin
            pos = (pos + 3) % 4;
            apply_stimulus(gray[pos][1], gray[pos][0], 8, pulses, fk);
            p2 += pulses;
        end
        check_output("dis_pulses", p2, 0);
        check_output("dis_count", {16'd0, count}, 32'd0);
        check_output("dis_dir", {31'd0, dir}, 32'd1);
        en = 1'b1;
        apply_stimulus(gray[pos][1], gray[pos][0], 12, pulses, fk);
        check_output("reen_pulses", pulses, 0);
        pos = (pos + 1) % 4;
        apply_stimulus(gray[pos][1], gray[pos][0], 10, pulses, fk);
        check_output("reen_step_count", {16'd0, count}, 32'd1);

        // Reach count 123 resting at 11, with err set, then reset mid-run.
        pos = (pos + 3) % 4;
        apply_stimulus(gray[pos][1], gray[pos][0], 10, pulses, fk);
        clr = 1'b1;
        apply_stimulus(gray[pos][1], gray[pos][0], 2, pulses, fk);
        for (int i = 0; i < 123; i++) begin
            pos = (pos + 1) % 4;
            apply_stimulus(gray[pos][1], gray[pos][0], 8, pulses, fk);
        end
        check_output("count123", {16'd0, count}, 32'd123);
        check_output("at_11", {30'd0, phase_a, phase_b}, 32'd3);
        apply_stimulus(1'b0, 1'b0, 10, pulses, fk);
        apply_stimulus(1'b1, 1'b1, 10, pulses, fk);
        check_output("pre_reset_err", {31'd0, err}, 32'd1);
        check_output("pre_reset_count", {16'd0, count}, 32'd123);
        #3;
        reset = 1'b1;
        #1;
        check_output("midreset_count", {16'd0, count}, 32'd0);
        check_output("midreset_err", {31'd0, err}, 32'd0);
        check_output("midreset_dir", {31'd0, dir}, 32'd1);
        check_output("midreset_step", {31'd0, step}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b1, FILT_LEN + 8, pulses, fk);
        check_output("postreset_pulses", pulses, 0);
        check_output("postreset_err", {31'd0, err}, 32'd0);
        apply_stimulus(1'b0, 1'b1, 10, pulses, fk);
        check_output("postreset_step", pulses, 1);
        check_output("postreset_count", {16'd0, count}, 32'd1);
        check_output("postreset_dir", {31'd0, dir}, 32'd1);

        // Random motion against a position-index model.
        m_pos = 3; m_count = 16'd1; m_dir = 1'b1; m_err = 1'b0;
        for (int it = 0; it < 80; it++) begin
            act     = $urandom_range(0, 9);
            en_r    = ($urandom_range(0, 3) != 0);
            do_clr  = ($urandom_range(0, 7) == 0);
            do_eclr = ($urandom_range(0, 5) == 0);
            hold    = $urandom_range(LAT + 2, LAT + 6);
            m_pulses = 0;
            if (do_clr) m_count = '0;
            if (do_eclr) m_err = 1'b0;
            en = en_r; clr = do_clr; err_clr = do_eclr;
            if (act <= 3) begin
                m_pos = (m_pos + 1) % 4;
                if (en_r) begin m_count = m_count + 1'b1; m_dir = 1'b1; m_pulses = 1; end
            end else if (act <= 6) begin
                m_pos = (m_pos + 3) % 4;
                if (en_r) begin m_count = m_count - 1'b1; m_dir = 1'b0; m_pulses = 1; end
            end else if (act == 7) begin
                m_pos = (m_pos + 2) % 4;
                if (en_r) m_err = 1'b1;
            end
            if (act >= 8) begin
                gl = $urandom_range(1, FILT_LEN - 1);
                ga = gray[m_pos][1];
                gb = gray[m_pos][0];
                if ($urandom_range(0, 1) == 0) ga = ~ga; else gb = ~gb;
                apply_stimulus(ga, gb, gl, pulses, fk);
                apply_stimulus(gray[m_pos][1], gray[m_pos][0], hold, p2, fk);
                pulses += p2;
            end else begin
                apply_stimulus(gray[m_pos][1], gray[m_pos][0], hold, pulses, fk);
            end
            check_output($sformatf("rnd%0d_pulses", it), pulses, m_pulses);
            check_output($sformatf("rnd%0d_count", it), {16'd0, count}, {16'd0, m_count});
            check_output($sformatf("rnd%0d_dir", it), {31'd0, dir}, {31'd0, m_dir});
            check_output($sformatf("rnd%0d_err", it), {31'd0, err}, {31'd0, m_err});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
